// File: rtl/ascon_block_feeder.sv
// Byte-stream front-end for ascon_top: packs AD then PT bytes into 64-bit rate blocks with 10* padding
// and paces start/data pulses to the core's permutation latency (the core has no backpressure).
module ascon_block_feeder #(
  parameter int INIT_WAIT = 13,
  parameter int BLOCK_GAP = 13
) (
  input  logic        clock_i,
  input  logic        resetb_i,
  input  logic        start_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  input  logic        byte_last_i,
  output logic        byte_ready_o,
  output logic        core_start_o,
  output logic [63:0] data_o,
  output logic        data_valid_o,
  output logic        final_o,
  output logic        busy_o,
  input  logic        end_i
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_INIT     = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_FINAL    = 3'd4;
  localparam logic [2:0] S_WAIT_END = 3'd5;

  localparam logic SEG_AD = 1'b0;
  localparam logic SEG_PT = 1'b1;

  localparam logic [63:0] PAD_BLOCK = 64'h8000_0000_0000_0000;

  logic [2:0]  state;
  logic [7:0]  gap;
  logic [63:0] fill;
  logic [2:0]  cnt;
  logic        complete;
  logic        padded;
  logic        pad_pending;
  logic        seg;

  logic        active;
  logic        issue;
  logic        last_pad;
  logic        accept;
  logic        final_fire;

  logic [63:0] fill_base;
  logic [2:0]  cnt_base;
  logic [63:0] fill_n;
  logic [2:0]  cnt_n;
  logic        complete_n;
  logic        padded_n;
  logic        pend_n;
  logic        seg_n;
  logic [5:0]  byte_shift;
  logic [5:0]  pad_shift;

  assign active     = (state == S_START) || (state == S_INIT) || (state == S_RUN);
  assign issue      = ((state == S_INIT) || (state == S_RUN)) && complete && (gap == 8'd0);
  assign last_pad   = padded && (seg == SEG_PT);
  assign final_fire = (state == S_FINAL) && (gap == 8'd0);
  assign busy_o     = (state != S_IDLE);

  // A byte may enter in the same cycle its predecessor block is issued, except after the closing PT block.
  assign byte_ready_o = active && !pad_pending && (!complete || (issue && !last_pad));
  assign accept       = byte_valid_i && byte_ready_o;

  always_comb begin
    fill_base  = fill;
    cnt_base   = cnt;
    complete_n = complete;
    padded_n   = padded;
    pend_n     = pad_pending;
    seg_n      = seg;
    if (issue) begin
      cnt_base = 3'd0;
      if (pad_pending && !padded) begin
        fill_base  = PAD_BLOCK;
        complete_n = 1'b1;
        padded_n   = 1'b1;
      end else begin
        fill_base  = 64'd0;
        complete_n = 1'b0;
        padded_n   = 1'b0;
        if (padded) begin
          pend_n = 1'b0;
          if (seg == SEG_AD) begin
            seg_n = SEG_PT;
          end
        end
      end
    end
    byte_shift = {3'(3'd7 - cnt_base), 3'b000};
    pad_shift  = {3'(3'd6 - cnt_base), 3'b000};
    fill_n     = fill_base;
    cnt_n      = cnt_base;
    if (accept) begin
      fill_n = fill_n | ({56'd0, byte_i} << byte_shift);
      cnt_n  = cnt_base + 3'd1;
      if (byte_last_i) begin
        complete_n = 1'b1;
        if (cnt_base != 3'd7) begin
          fill_n   = fill_n | ({56'd0, 8'h80} << pad_shift);
          padded_n = 1'b1;
        end else begin
          pend_n   = 1'b1;
          padded_n = 1'b0;
        end
      end else if (cnt_base == 3'd7) begin
        complete_n = 1'b1;
      end
    end
  end

  // Gap counter: one shared pacing timer for the init wait and the inter-block spacing.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      gap <= 8'd0;
    end else if (issue || final_fire) begin
      gap <= 8'(BLOCK_GAP - 1);
    end else if (state == S_START) begin
      gap <= 8'(INIT_WAIT - 1);
    end else if (gap != 8'd0) begin
      gap <= gap - 8'd1;
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state        <= S_IDLE;
      fill         <= 64'd0;
      cnt          <= 3'd0;
      complete     <= 1'b0;
      padded       <= 1'b0;
      pad_pending  <= 1'b0;
      seg          <= SEG_AD;
      data_o       <= 64'd0;
      data_valid_o <= 1'b0;
      final_o      <= 1'b0;
      core_start_o <= 1'b0;
    end else begin
      data_valid_o <= 1'b0;
      final_o      <= 1'b0;
      core_start_o <= 1'b0;
      if (state == S_IDLE) begin
        if (start_i) begin
          fill        <= 64'd0;
          cnt         <= 3'd0;
          complete    <= 1'b0;
          padded      <= 1'b0;
          pad_pending <= 1'b0;
          seg         <= SEG_AD;
        end
      end else begin
        fill        <= fill_n;
        cnt         <= cnt_n;
        complete    <= complete_n;
        padded      <= padded_n;
        pad_pending <= pend_n;
        seg         <= seg_n;
      end
      if (issue) begin
        data_o       <= fill;
        data_valid_o <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state <= S_START;
          end
        end
        S_START: begin
          core_start_o <= 1'b1;
          state        <= S_INIT;
        end
        S_INIT, S_RUN: begin
          if (issue && last_pad) begin
            state <= S_FINAL;
          end else if ((state == S_INIT) && (gap == 8'd0)) begin
            state <= S_RUN;
          end
        end
        S_FINAL: begin
          if (final_fire) begin
            data_o       <= 64'd0;
            data_valid_o <= 1'b1;
            final_o      <= 1'b1;
            state        <= S_WAIT_END;
          end
        end
        S_WAIT_END: begin
          if (end_i) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
